// File: rtl/multiword_add_sequencer_if.sv
// Operand/result handshake plus external adder-slice hookup for multiword_add_sequencer.
// slave = the sequencer side, master = the environment (source, sink and adder slice).
interface multiword_add_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WORDS      = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_WIDTH*WORDS-1:0] in_a;
    logic [DATA_WIDTH*WORDS-1:0] in_b;
    logic                        in_sub;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH*WORDS-1:0] out_sum;
    logic                        out_cout;
    logic                        out_ovf;
    logic                        busy;
    logic [DATA_WIDTH-1:0]       add_a;
    logic [DATA_WIDTH-1:0]       add_b;
    logic                        add_cin;
    logic [DATA_WIDTH-1:0]       add_sum;
    logic                        add_cout;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready, add_sum, add_cout,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy, add_a, add_b, add_cin
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready, add_sum, add_cout,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy, add_a, add_b, add_cin
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract controller: drives one external DATA_WIDTH-bit adder slice,
// one word per cycle LSW first, and assembles the wide result with carry and overflow.
module multiword_add_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int WORDS      = 4
) (
    input logic                        clk,
    input logic                        rst,
    multiword_add_sequencer_if.slave   bus
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_q;
    logic [IDX_W-1:0]            idx_q;
    logic                        carry_q;
    logic [DATA_WIDTH*WORDS-1:0] a_q;
    logic [DATA_WIDTH*WORDS-1:0] b_q;
    logic                        sub_q;
    logic [DATA_WIDTH*WORDS-1:0] sum_q;
    logic [DATA_WIDTH*WORDS-1:0] sum_d;
    logic                        cout_q;
    logic                        ovf_q;
    logic [DATA_WIDTH-1:0]       word_a;
    logic [DATA_WIDTH-1:0]       word_b;
    logic                        run;
    logic                        cmsb;

    assign run = (state_q == RUN);

    // Word select and result-word insertion share one decode of idx_q.
    always_comb begin
        sum_d  = sum_q;
        word_a = '0;
        word_b = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (IDX_W'(w) == idx_q) begin
                word_a = a_q[w*DATA_WIDTH +: DATA_WIDTH];
                word_b = b_q[w*DATA_WIDTH +: DATA_WIDTH];
                sum_d[w*DATA_WIDTH +: DATA_WIDTH] = bus.add_sum;
            end
        end
    end

    assign bus.add_a   = run ? word_a : '0;
    assign bus.add_b   = run ? (word_b ^ {DATA_WIDTH{sub_q}}) : '0;
    assign bus.add_cin = run ? ((idx_q == '0) ? sub_q : carry_q) : 1'b0;

    // Carry into the sign bit, recovered from the slice's MSB inputs and sum.
    assign cmsb = bus.add_a[DATA_WIDTH-1] ^ bus.add_b[DATA_WIDTH-1] ^ bus.add_sum[DATA_WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        sub_q   <= bus.in_sub;
                        sum_q   <= '0;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= bus.add_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= bus.add_cout;
                        ovf_q   <= cmsb ^ bus.add_cout;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
endmodule
